// File: rtl/ex_stage.sv
//============================================================================
// Module      : ex_stage
// Description : Execute stage of the pipelined RV32 core. Forwards operands
//               from MEM and WB, computes the ALU result and zero flag, and
//               registers everything into the EX/MEM pipeline register.
//               Optional iterative shift-add multiplier for MUL, compiled in
//               when the macro RV32M_MUL_EN is defined; it holds the front
//               of the pipeline through ex_stall until the product is ready.
// Ports       : clk, rstn (sync, active-low), Flush
//               EX_*  : decoded instruction from the ID/EX register
//               WB_*  : writeback result used for forwarding
//               ex_stall : combinational hold request to PC/IF/ID/ID-EX
//               MEM_* : registered EX/MEM pipeline outputs
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ex_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Flush,
    input  logic [1:0]  EX_ALUOp,
    input  logic        EX_ALUSrc,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_MemtoReg,
    input  logic        EX_RegWrite,
    input  logic        EX_ioRead,
    input  logic        EX_ioWrite,
    input  logic [4:0]  EX_rs1_addr,
    input  logic [4:0]  EX_rs2_addr,
    input  logic [4:0]  EX_rd_addr,
    input  logic [31:0] EX_ReadData1,
    input  logic [31:0] EX_ReadData2,
    input  logic [31:0] EX_imm32,
    input  logic [2:0]  EX_funct3,
    input  logic [6:0]  EX_funct7,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_rd_addr,
    input  logic [31:0] WB_wdata,
    output logic        ex_stall,
    output logic [31:0] MEM_alu_result,
    output logic [31:0] MEM_rs2_v,
    output logic [4:0]  MEM_rd_addr,
    output logic [2:0]  MEM_funct3,
    output logic        MEM_zero,
    output logic        MEM_MemRead,
    output logic        MEM_MemWrite,
    output logic        MEM_MemtoReg,
    output logic        MEM_RegWrite,
    output logic        MEM_ioRead,
    output logic        MEM_ioWrite
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_FN  = 2'b10;

    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic [31:0] w_op_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_alu;
    logic [5:0]  w_ex_ctrl;

    // Control bits packed as {MemRead, MemWrite, MemtoReg, RegWrite, ioRead, ioWrite}
    assign w_ex_ctrl = {EX_MemRead, EX_MemWrite, EX_MemtoReg,
                        EX_RegWrite, EX_ioRead, EX_ioWrite};

    // Forwarding: the younger MEM result wins over WB; x0 is never forwarded.
    always_comb begin
        w_fwd_a = EX_ReadData1;
        if (MEM_RegWrite && (MEM_rd_addr != 5'd0) && (MEM_rd_addr == EX_rs1_addr))
            w_fwd_a = MEM_alu_result;
        else if (WB_RegWrite && (WB_rd_addr != 5'd0) && (WB_rd_addr == EX_rs1_addr))
            w_fwd_a = WB_wdata;
    end

    always_comb begin
        w_fwd_b = EX_ReadData2;
        if (MEM_RegWrite && (MEM_rd_addr != 5'd0) && (MEM_rd_addr == EX_rs2_addr))
            w_fwd_b = MEM_alu_result;
        else if (WB_RegWrite && (WB_rd_addr != 5'd0) && (WB_rd_addr == EX_rs2_addr))
            w_fwd_b = WB_wdata;
    end

    assign w_op_b  = EX_ALUSrc ? EX_imm32 : w_fwd_b;
    assign w_shamt = w_op_b[4:0];

    always_comb begin
        w_alu = 32'd0;
        case (EX_ALUOp)
            c_OP_ADD: w_alu = w_fwd_a + w_op_b;
            c_OP_SUB: w_alu = w_fwd_a - w_op_b;
            c_OP_FN: begin
                case (EX_funct3)
                    3'b000: w_alu = (EX_funct7[5] && !EX_ALUSrc) ? (w_fwd_a - w_op_b)
                                                                 : (w_fwd_a + w_op_b);
                    3'b001: w_alu = w_fwd_a << w_shamt;
                    3'b010: w_alu = ($signed(w_fwd_a) < $signed(w_op_b)) ? 32'd1 : 32'd0;
                    3'b011: w_alu = (w_fwd_a < w_op_b) ? 32'd1 : 32'd0;
                    3'b100: w_alu = w_fwd_a ^ w_op_b;
                    3'b101: w_alu = EX_funct7[5] ? 32'($signed(w_fwd_a) >>> w_shamt)
                                                 : (w_fwd_a >> w_shamt);
                    3'b110: w_alu = w_fwd_a | w_op_b;
                    default: w_alu = w_fwd_a & w_op_b;
                endcase
            end
            default: w_alu = 32'd0;
        endcase
    end

    // Signals presented to the EX/MEM register by the multiplier.
    logic        w_stall;
    logic        w_mul_done;
    logic [31:0] w_mul_result;
    logic [4:0]  w_mul_rd;
    logic [2:0]  w_mul_f3;
    logic [5:0]  w_mul_ctrl;

`ifdef RV32M_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_mcand;
    logic [31:0] r_mplr;
    logic [31:0] r_acc;
    logic [4:0]  r_cnt;
    logic [4:0]  r_mul_rd;
    logic [2:0]  r_mul_f3;
    logic [5:0]  r_mul_ctrl;
    logic        w_mul_det;

    assign w_mul_det = (EX_ALUOp == c_OP_FN) && !EX_ALUSrc &&
                       (EX_funct7 == 7'b0000001) && (EX_funct3 == 3'b000);

    // Shift-add: multiplicand moves left, multiplier right, one bit per
    // cycle. Only the low 32 product bits are kept, which is all MUL needs.
    always_ff @(posedge clk) begin
        if (!rstn || Flush) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= 32'd0;
            r_mcand    <= 32'd0;
            r_mplr     <= 32'd0;
            r_mul_rd   <= 5'd0;
            r_mul_f3   <= 3'd0;
            r_mul_ctrl <= 6'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mul_det) begin
                        r_state    <= S_BUSY;
                        r_mcand    <= w_fwd_a;
                        r_mplr     <= w_op_b;
                        r_acc      <= 32'd0;
                        r_cnt      <= 5'd0;
                        r_mul_rd   <= EX_rd_addr;
                        r_mul_f3   <= EX_funct3;
                        r_mul_ctrl <= w_ex_ctrl;
                    end
                end
                S_BUSY: begin
                    r_acc   <= r_acc + (r_mplr[0] ? r_mcand : 32'd0);
                    r_mcand <= r_mcand << 1;
                    r_mplr  <= r_mplr >> 1;
                    if (r_cnt == 5'd31)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt + 5'd1;
                end
                // The held MUL is still in ID/EX here; going straight back
                // to IDLE (ignoring w_mul_det) keeps it from restarting.
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_stall      = ((r_state == S_IDLE) && w_mul_det) || (r_state == S_BUSY);
    assign w_mul_done   = (r_state == S_DONE);
    assign w_mul_result = r_acc;
    assign w_mul_rd     = r_mul_rd;
    assign w_mul_f3     = r_mul_f3;
    assign w_mul_ctrl   = r_mul_ctrl;
`else
    // Without the multiplier only funct7[5] is decoded.
    logic w_unused_f7;
    assign w_unused_f7  = ^{EX_funct7[6], EX_funct7[4:0]};
    assign w_stall      = 1'b0;
    assign w_mul_done   = 1'b0;
    assign w_mul_result = 32'd0;
    assign w_mul_rd     = 5'd0;
    assign w_mul_f3     = 3'd0;
    assign w_mul_ctrl   = 6'd0;
`endif

    // Reset and Flush drop the stall in the same cycle.
    assign ex_stall = rstn && !Flush && w_stall;

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (!rstn || Flush) begin
            MEM_alu_result <= 32'd0;
            MEM_rs2_v      <= 32'd0;
            MEM_rd_addr    <= 5'd0;
            MEM_funct3     <= 3'd0;
            MEM_zero       <= 1'b0;
            {MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
             MEM_RegWrite, MEM_ioRead, MEM_ioWrite} <= 6'd0;
        end else if (w_mul_done) begin
            MEM_alu_result <= w_mul_result;
            MEM_rs2_v      <= 32'd0;
            MEM_rd_addr    <= w_mul_rd;
            MEM_funct3     <= w_mul_f3;
            MEM_zero       <= (w_mul_result == 32'd0);
            {MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
             MEM_RegWrite, MEM_ioRead, MEM_ioWrite} <= w_mul_ctrl;
        end else if (w_stall) begin
            MEM_alu_result <= 32'd0;
            MEM_rs2_v      <= 32'd0;
            MEM_rd_addr    <= 5'd0;
            MEM_funct3     <= 3'd0;
            MEM_zero       <= 1'b0;
            {MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
             MEM_RegWrite, MEM_ioRead, MEM_ioWrite} <= 6'd0;
        end else begin
            MEM_alu_result <= w_alu;
            MEM_rs2_v      <= w_fwd_b;
            MEM_rd_addr    <= EX_rd_addr;
            MEM_funct3     <= EX_funct3;
            MEM_zero       <= (w_alu == 32'd0);
            {MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
             MEM_RegWrite, MEM_ioRead, MEM_ioWrite} <= w_ex_ctrl;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
//============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: table of ALU vectors plus
//               hand-written forwarding, flush, reset and multiply sequences.
//               Multiply timing sequences are built when RV32M_MUL_EN is set.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Flush;
    logic [1:0]  EX_ALUOp;
    logic        EX_ALUSrc;
    logic        EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite, EX_ioRead, EX_ioWrite;
    logic [4:0]  EX_rs1_addr, EX_rs2_addr, EX_rd_addr;
    logic [31:0] EX_ReadData1, EX_ReadData2, EX_imm32;
    logic [2:0]  EX_funct3;
    logic [6:0]  EX_funct7;
    logic        WB_RegWrite;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_wdata;
    logic        ex_stall;
    logic [31:0] MEM_alu_result, MEM_rs2_v;
    logic [4:0]  MEM_rd_addr;
    logic [2:0]  MEM_funct3;
    logic        MEM_zero;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite, MEM_ioRead, MEM_ioWrite;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rstn(rstn), .Flush(Flush),
        .EX_ALUOp(EX_ALUOp), .EX_ALUSrc(EX_ALUSrc),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_MemtoReg(EX_MemtoReg),
        .EX_RegWrite(EX_RegWrite), .EX_ioRead(EX_ioRead), .EX_ioWrite(EX_ioWrite),
        .EX_rs1_addr(EX_rs1_addr), .EX_rs2_addr(EX_rs2_addr), .EX_rd_addr(EX_rd_addr),
        .EX_ReadData1(EX_ReadData1), .EX_ReadData2(EX_ReadData2), .EX_imm32(EX_imm32),
        .EX_funct3(EX_funct3), .EX_funct7(EX_funct7),
        .WB_RegWrite(WB_RegWrite), .WB_rd_addr(WB_rd_addr), .WB_wdata(WB_wdata),
        .ex_stall(ex_stall),
        .MEM_alu_result(MEM_alu_result), .MEM_rs2_v(MEM_rs2_v),
        .MEM_rd_addr(MEM_rd_addr), .MEM_funct3(MEM_funct3), .MEM_zero(MEM_zero),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_MemtoReg(MEM_MemtoReg),
        .MEM_RegWrite(MEM_RegWrite), .MEM_ioRead(MEM_ioRead), .MEM_ioWrite(MEM_ioWrite)
    );

    // Control bits as {MemRead, MemWrite, MemtoReg, RegWrite, ioRead, ioWrite}
    localparam logic [5:0] c_RW = 6'b000100;
    localparam logic [5:0] c_SW = 6'b010000;

    typedef struct {
        logic [1:0]  op;
        logic        src;
        logic [5:0]  ctrl;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        ez;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [5:0] mem_ctrl();
        return {MEM_MemRead, MEM_MemWrite, MEM_MemtoReg, MEM_RegWrite, MEM_ioRead, MEM_ioWrite};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic src, input logic [5:0] ctrl,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [2:0] f3, input logic [6:0] f7);
        EX_ALUOp = op;
        EX_ALUSrc = src;
        {EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite, EX_ioRead, EX_ioWrite} = ctrl;
        EX_rs1_addr = rs1;
        EX_rs2_addr = rs2;
        EX_rd_addr = rd;
        EX_ReadData1 = d1;
        EX_ReadData2 = d2;
        EX_imm32 = imm;
        EX_funct3 = f3;
        EX_funct7 = f7;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        WB_RegWrite = we;
        WB_rd_addr = rd;
        WB_wdata = d;
    endtask

    task automatic nop();
        drive(2'b00, 1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 7'd0);
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_res"}, MEM_alu_result, 32'd0);
        chk({name, "_ctl"}, {26'd0, mem_ctrl()}, 32'd0);
        chk({name, "_rd"}, {27'd0, MEM_rd_addr}, 32'd0);
    endtask

    initial begin
        // op, src, ctrl, f3, f7, a(rs1), b(rs2), imm, expected, zero
        vecs[0]  = '{2'b10, 1'b1, c_RW, 3'd0, 7'h00, 32'd5,        32'd0,        32'd7, 32'd12,       1'b0};
        vecs[1]  = '{2'b00, 1'b0, c_RW, 3'd0, 7'h00, 32'd100,      32'hFFFFFF9C, 32'd0, 32'd0,        1'b1};
        vecs[2]  = '{2'b01, 1'b0, 6'd0, 3'd0, 7'h00, 32'd7,        32'd7,        32'd0, 32'd0,        1'b1};
        vecs[3]  = '{2'b10, 1'b0, c_RW, 3'd0, 7'h20, 32'd10,       32'd3,        32'd0, 32'd7,        1'b0};
        vecs[4]  = '{2'b10, 1'b1, c_RW, 3'd0, 7'h20, 32'd10,       32'd0,        32'd3, 32'd13,       1'b0};
        vecs[5]  = '{2'b10, 1'b0, c_RW, 3'd1, 7'h00, 32'd1,        32'h21,       32'd0, 32'd2,        1'b0};
        vecs[6]  = '{2'b10, 1'b0, c_RW, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd1,        1'b0};
        vecs[7]  = '{2'b10, 1'b0, c_RW, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd0,        1'b1};
        vecs[8]  = '{2'b10, 1'b0, c_RW, 3'd3, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0, 32'd1,        1'b0};
        vecs[9]  = '{2'b10, 1'b0, c_RW, 3'd4, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'h00000FF0, 1'b0};
        vecs[10] = '{2'b10, 1'b0, c_RW, 3'd5, 7'h00, 32'h80000000, 32'd4,        32'd0, 32'h08000000, 1'b0};
        vecs[11] = '{2'b10, 1'b0, c_RW, 3'd5, 7'h20, 32'h80000000, 32'd4,        32'd0, 32'hF8000000, 1'b0};
        vecs[12] = '{2'b10, 1'b0, c_RW, 3'd6, 7'h00, 32'h0F,       32'hF0,       32'd0, 32'hFF,       1'b0};
        vecs[13] = '{2'b10, 1'b0, c_RW, 3'd7, 7'h00, 32'h0F,       32'hF0,       32'd0, 32'd0,        1'b1};
        vecs[14] = '{2'b11, 1'b0, c_RW, 3'd0, 7'h00, 32'd5,        32'd6,        32'd0, 32'd0,        1'b1};
        vecs[15] = '{2'b00, 1'b0, c_RW, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd0, 32'd0,        1'b1};
        vecs[16] = '{2'b00, 1'b1, c_SW, 3'd2, 7'h00, 32'h100,      32'hCAFEBABE, 32'd8, 32'h108,      1'b0};
        vecs[17] = '{2'b01, 1'b0, 6'b101011, 3'd5, 7'h00, 32'd5,   32'd9,        32'd0, 32'hFFFFFFFC, 1'b0};
        vecs[18] = '{2'b10, 1'b0, 6'b011101, 3'd2, 7'h00, 32'd5,   32'd3,        32'd0, 32'd0,        1'b1};

        // Reset; a MUL encoding on the inputs must not raise the stall.
        rstn = 1'b0;
        Flush = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd7, 32'hFFFFFFFF, 32'd3, 32'd0, 3'd0, 7'h01);
        step();
        step();
        chk_bubble("reset");
        chk("reset_rs2", MEM_rs2_v, 32'd0);
        chk("reset_zero", {31'd0, MEM_zero}, 32'd0);
        chk("reset_stall", {31'd0, ex_stall}, 32'd0);
        rstn = 1'b1;
        nop();
        step();

        // ALU table: rs1=x1, rs2=x2, rd=x5, so nothing forwards between vectors.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].op, vecs[i].src, vecs[i].ctrl, 5'd1, 5'd2, 5'd5,
                  vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].f3, vecs[i].f7);
            step();
            chk($sformatf("v%0d_res", i), MEM_alu_result, vecs[i].exp);
            chk($sformatf("v%0d_zero", i), {31'd0, MEM_zero}, {31'd0, vecs[i].ez});
            chk($sformatf("v%0d_ctl", i), {26'd0, mem_ctrl()}, {26'd0, vecs[i].ctrl});
            chk($sformatf("v%0d_f3", i), {29'd0, MEM_funct3}, {29'd0, vecs[i].f3});
            chk($sformatf("v%0d_rd", i), {27'd0, MEM_rd_addr}, 32'd5);
            chk($sformatf("v%0d_rs2", i), MEM_rs2_v, vecs[i].b);
        end

        // MEM forward into SUB; WB also matches x3 but MEM must win.
        drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 3'd0, 7'h00);
        step();
        chk("fwdm_add", MEM_alu_result, 32'd13);
        drive(2'b10, 1'b0, c_RW, 5'd3, 5'd1, 5'd4, 32'h0000DEAD, 32'd10, 32'd0, 3'd0, 7'h20);
        set_wb(1'b1, 5'd3, 32'd99);
        step();
        chk("fwdm_sub", MEM_alu_result, 32'd3);
        set_wb(1'b0, 5'd0, 32'd0);

        // WB forward after one bubble.
        drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 3'd0, 7'h00);
        step();
        nop();
        step();
        chk("fwdw_bubble", {31'd0, MEM_RegWrite}, 32'd0);
        drive(2'b10, 1'b0, c_RW, 5'd3, 5'd1, 5'd4, 32'h0000DEAD, 32'd10, 32'd0, 3'd0, 7'h20);
        set_wb(1'b1, 5'd3, 32'd13);
        step();
        chk("fwdw_sub", MEM_alu_result, 32'd3);
        set_wb(1'b0, 5'd0, 32'd0);

        // Store data forwarded from MEM.
        drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 3'd0, 7'h00);
        step();
        drive(2'b00, 1'b1, c_SW, 5'd0, 5'd3, 5'd0, 32'd0, 32'h0BAD0BAD, 32'd4, 3'd2, 7'h00);
        step();
        chk("fwd_store", MEM_rs2_v, 32'd13);
        chk("fwd_store_addr", MEM_alu_result, 32'd4);

        // x0 is never forwarded from MEM or WB.
        drive(2'b10, 1'b1, c_RW, 5'd1, 5'd0, 5'd0, 32'd50, 32'd0, 32'd27, 3'd0, 7'h00);
        step();
        chk("x0_addi", MEM_alu_result, 32'd77);
        drive(2'b10, 1'b0, c_RW, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0, 32'd0, 3'd0, 7'h00);
        set_wb(1'b1, 5'd0, 32'd5);
        step();
        chk("x0_nofwd", MEM_alu_result, 32'd0);
        set_wb(1'b0, 5'd0, 32'd0);

        // Flush turns a live instruction into a bubble.
        drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 3'd0, 7'h00);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk_bubble("flush");

        // Reset after a completed instruction clears the EX/MEM register.
        step();
        chk("prereset_add", MEM_alu_result, 32'd13);
        rstn = 1'b0;
        step();
        chk_bubble("rst_mid");
        rstn = 1'b1;
        nop();
        step();

`ifndef RV32M_MUL_EN
        // Without the multiplier a MUL encoding is a plain ADD.
        drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd7, 32'hFFFFFFFF, 32'd3, 32'd0, 3'd0, 7'h01);
        #1;
        chk("nomul_stall", {31'd0, ex_stall}, 32'd0);
        step();
        chk("nomul_add", MEM_alu_result, 32'd2);
        chk("nomul_rw", {31'd0, MEM_RegWrite}, 32'd1);
`else
        begin
            int n;
            logic bub_ok;
            // Full MUL: 33 stall cycles with bubbles, one DONE cycle, result.
            drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd7, 32'hFFFFFFFF, 32'd3, 32'd0, 3'd0, 7'h01);
            #1;
            n = 0;
            bub_ok = 1'b1;
            while (ex_stall === 1'b1 && n < 100) begin
                n++;
                step();
                if (MEM_RegWrite !== 1'b0) bub_ok = 1'b0;
            end
            chk("mul_stall_cycles", n, 32'd33);
            chk("mul_bubbles", {31'd0, bub_ok}, 32'd1);
            step();
            chk("mul_result", MEM_alu_result, 32'hFFFFFFFD);
            chk("mul_rw", {31'd0, MEM_RegWrite}, 32'd1);
            chk("mul_rd", {27'd0, MEM_rd_addr}, 32'd7);
            chk("mul_zero", {31'd0, MEM_zero}, 32'd0);
            drive(2'b10, 1'b0, c_RW, 5'd7, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 3'd0, 7'h00);
            #1;
            chk("mul_no_restart", {31'd0, ex_stall}, 32'd0);
            step();
            chk("mul_fwd", MEM_alu_result, 32'hFFFFFFFD);

            // Flush at BUSY count 10.
            drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd7, 32'hFFFFFFFF, 32'd3, 32'd0, 3'd0, 7'h01);
            repeat (11) step();
            chk("mulf_busy", {31'd0, ex_stall}, 32'd1);
            Flush = 1'b1;
            #1;
            chk("mulf_stall_drop", {31'd0, ex_stall}, 32'd0);
            step();
            Flush = 1'b0;
            chk_bubble("mulf");
            drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd9, 32'd10, 32'd3, 32'd0, 3'd0, 7'h00);
            #1;
            chk("mulf_idle", {31'd0, ex_stall}, 32'd0);
            step();
            chk("mulf_add", MEM_alu_result, 32'd13);

            // Reset in the middle of a multiply.
            drive(2'b10, 1'b0, c_RW, 5'd1, 5'd2, 5'd7, 32'hFFFFFFFF, 32'd3, 32'd0, 3'd0, 7'h01);
            repeat (5) step();
            rstn = 1'b0;
            step();
            chk_bubble("mulr");
            chk("mulr_stall", {31'd0, ex_stall}, 32'd0);
            rstn = 1'b1;
            nop();
            #1;
            chk("mulr_idle", {31'd0, ex_stall}, 32'd0);
            step();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined RV32 core, sitting directly downstream of the ID/EX pipeline register and feeding the data-memory stage. It forwards operands from MEM and WB, computes the ALU result and branch-zero flag, and registers everything into the EX/MEM pipeline register. An optional iterative multiplier for `MUL` holds the front of the pipeline through `ex_stall` until its result is ready.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: core clock, all state on rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `Flush` in 1: kill the instruction in EX and any multiply in flight.
- `EX_ALUOp` in 2: 00 add, 01 subtract (branch compare), 10 decode by funct3/funct7.
- `EX_ALUSrc` in 1: 1 selects `EX_imm32` as operand B.
- `EX_MemRead`, `EX_MemWrite`, `EX_MemtoReg`, `EX_RegWrite`, `EX_ioRead`, `EX_ioWrite` in 1 each: control bits carried to MEM.
- `EX_rs1_addr`, `EX_rs2_addr`, `EX_rd_addr` in 5 each: source and destination register numbers.
- `EX_ReadData1`, `EX_ReadData2`, `EX_imm32` in 32 each: register-file values and immediate.
- `EX_funct3` in 3, `EX_funct7` in 7: function fields.
- `WB_RegWrite` in 1, `WB_rd_addr` in 5, `WB_wdata` in 32: writeback-stage result, used for forwarding.
- `ex_stall` out 1: combinational; while high, upstream must hold PC, IF/ID and ID/EX unchanged.
- `MEM_alu_result` out 32: registered ALU or multiply result.
- `MEM_rs2_v` out 32: registered, forwarded rs2 value (store data).
- `MEM_rd_addr` out 5, `MEM_funct3` out 3, `MEM_zero` out 1: registered.
- `MEM_MemRead`, `MEM_MemWrite`, `MEM_MemtoReg`, `MEM_RegWrite`, `MEM_ioRead`, `MEM_ioWrite` out 1 each: registered control bits.

## Operation
- **Forwarding, per source `rsN`:**
  - If `MEM_RegWrite && MEM_rd_addr != 0 && MEM_rd_addr == rsN`, use `MEM_alu_result`.
  - Otherwise, if `WB_RegWrite && WB_rd_addr != 0 && WB_rd_addr == rsN`, use `WB_wdata`.
  - Otherwise use `EX_ReadDataN`.
  - MEM has priority over WB.
  - Load-use hazards are not handled here; the hazard unit stalls one cycle upstream.
- **Operands:**
  - A = forwarded rs1.
  - B = `EX_imm32` if `EX_ALUSrc`, otherwise forwarded rs2.
  - Store data is always forwarded rs2.
- **ALU:**
  - ALUOp 00: A+B.
  - ALUOp 01: A−B.
  - ALUOp 10, funct3 000: SUB when `funct7[5] && !EX_ALUSrc`, otherwise ADD.
  - ALUOp 10, remaining funct3: 001 SLL, 010 SLT (signed), 011 SLTU, 100 XOR, 101 SRA if `funct7[5]` else SRL, 110 OR, 111 AND.
  - Shift amount is B[4:0]. All arithmetic wraps modulo 2^32.
  - ALUOp 11 produces 0.
  - `zero` = (result == 0).
- **EX/MEM register:**
  - Each cycle it loads the ALU result, forwarded rs2, rd, funct3, zero and control bits.
  - On reset or `Flush`, every output goes to 0 (bubble). Flush has priority over a normal load.
  - While `ex_stall` is high, a bubble (all control bits 0) is loaded.
- **Multiplier FSM** (only with the macro below), states IDLE, BUSY, DONE:
  - IDLE→BUSY when ALUOp=10, ALUSrc=0, funct7=0000001, funct3=000. The transition latches A, B, rd, funct3 and the control bits, clears the accumulator and sets count=0.
  - BUSY: shift-add, one multiplier bit per cycle. When count=31, move to DONE; otherwise increment count.
  - DONE: EX/MEM loads the latched low 32 bits of the product plus the latched controls; `zero` is computed on the product. The FSM then returns to IDLE unconditionally, and the held MUL is not restarted.
  - `ex_stall` = (IDLE && MUL detected) || BUSY. It is low in DONE, so upstream advances at the edge that ends DONE.
  - Reset or `Flush` in any state returns the FSM to IDLE, drops the latched instruction and deasserts `ex_stall` immediately.

## Timing
- Non-MUL instruction: 1 cycle in EX; results visible at MEM outputs after the next rising edge.
- MUL: `ex_stall` high for exactly 33 cycles (detect cycle + 32 BUSY), then 1 DONE cycle.
  - The result appears at the MEM outputs on the edge that ends DONE, 34 cycles after the MUL enters EX.
  - Forwarding from that result to the next instruction works normally.
- Reset value of every registered output is 0. `ex_stall` is 0 during reset.

## Configuration
- `RV32M_MUL_EN` defined: multiplier FSM and stall logic are compiled in.
- Undefined: no FSM; `ex_stall` is tied to 0. funct7=0000001 with funct3=000 decodes as ADD, because `funct7[5]` is 0.

## Test plan
- ADDI: rs1 value 5, imm 7, ALUSrc=1 → next edge `MEM_alu_result`=12, `MEM_RegWrite`=1, `MEM_zero`=0.
- Back-to-back `ADD x3,x1,x2` then `SUB x4,x3,x1`, with x1=10, x2=3 and a stale x3 read value → SUB uses the MEM-forwarded 13, result 3. Repeat with one bubble between them → WB forward, result still 3.
- Forward to x0: MEM rd=0 with RegWrite=1 → no forward; the register value is used.
- `MUL` 0xFFFF_FFFF × 3 (macro on) → `ex_stall` high for 33 cycles with bubbles in MEM, then `MEM_alu_result`=0xFFFF_FFFD and RegWrite=1.
- `Flush` at BUSY count 10 → the next edge gives a bubble, `ex_stall`=0 and FSM IDLE; a following ADD completes normally.
- `rstn`=0 mid-MUL → all outputs 0 after the edge; with the macro off, a MUL encoding gives A+B and no stall.
